bin2bcd_seq: RTL and testbench
==============================

# bin2bcd_seq

Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock. Sits between the sine-table ROM output and the five hex_to_7seg digit decoders, and is the registered, handshaked replacement for the combinational 16-bit converter on that path. It captures a binary word on request, converts it over WIDTH cycles and presents five held BCD digits with a one-cycle completion pulse.

## Interface
- WIDTH, 16: width of BIN; legal range 1..16, since five digits cover 0..65535.
- CLOCK_50  input  1  clock; all state changes on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- START  input  1  conversion request; sampled only while idle.
- AUTO  input  1  continuous mode; while high, behaves as START held high.
- BIN  input  WIDTH  unsigned value; captured at the accepting edge only.
- BUSY  output  1  high while a conversion is in progress.
- DONE  output  1  one-cycle pulse; BCD outputs updated in the same cycle.
- BCD0  output  4  units digit.
- BCD1  output  4  tens digit.
- BCD2  output  4  hundreds digit.
- BCD3  output  4  thousands digit.
- BCD4  output  4  ten-thousands digit.

## Operation
- Two states:
  - IDLE
  - SHIFT, with a bit counter (5 bits, counting WIDTH down to 1).
- Working registers:
  - shift register for the binary operand (WIDTH bits).
  - 20-bit scratch holding five BCD nibbles.
- IDLE:
  - If (START | AUTO) = 1 at an edge: load BIN into the shift register, clear the scratch, set the counter to WIDTH, go to SHIFT.
  - Otherwise hold all state.
- SHIFT, every edge:
  - Correct each scratch nibble: any nibble ≥ 5 gets +3. Carries never cross nibble boundaries.
  - Shift {scratch, operand} left by one; the operand MSB enters scratch bit 0.
  - Decrement the counter.
- Last shift (counter = 1):
  - Write the corrected-and-shifted scratch straight into BCD4..BCD0.
  - Set DONE = 1 and return to IDLE.
- DONE is registered. It is high for exactly one cycle, then clears on the next edge unless a further completion occurs there.
- BCD outputs are registered and hold their value until the next completion. They never show intermediate scratch values.
- BUSY = 1 exactly while in SHIFT.
- START asserted during SHIFT is ignored. It is not queued.
- Changes on BIN during SHIFT have no effect.
- Digits above the value's magnitude read 0. For any WIDTH, BCD4 ≤ 6 and every digit ≤ 9.

## Timing
- Reset (asynchronous, immediate), then held for as long as RESET is high:
  - state IDLE, counter 0, scratch 0, operand 0.
  - BUSY = 0, DONE = 0, BCD0..BCD4 = 0.
- Latency: START sampled at edge E0, then:
  - BUSY high from E0 through E(WIDTH).
  - DONE high and new digits valid from E(WIDTH) to E(WIDTH+1).
  - Default WIDTH: 16 cycles.
- Back-to-back conversions:
  - START high during the DONE cycle is accepted at E(WIDTH+1), because the state is IDLE.
  - Maximum throughput is one conversion per WIDTH+1 cycles.
  - With AUTO held high, DONE pulses every WIDTH+1 cycles.
- Reset mid-conversion: aborts immediately. No DONE is produced, and the outputs are zeroed (previous result lost).
- START and RESET together: RESET wins.

## Test plan
- Reset release, BIN=0, START pulse: BUSY high for 16 cycles, then DONE for one cycle with all digits 0; BUSY and DONE never high together.
- BIN=16'hFFFF, START: after 16 cycles BCD4..BCD0 = 6,5,5,3,5; outputs then held while BIN changes and START stays low.
- BIN=1023, START; drive BIN=7 and pulse START mid-conversion: result is 0,1,0,2,3 after exactly 16 cycles, with no second conversion.
- AUTO=1, BIN stepping through 0, 9, 10, 99, 100, 9999, 10000, 65534 (one value per conversion):
  - DONE period is 17 cycles.
  - Each result matches the decimal value (e.g. 10000 → 1,0,0,0,0).
- Result 12345 held, new conversion started, RESET asserted at shift 8: all outputs 0 asynchronously, no DONE; a fresh START afterwards converts correctly.
- WIDTH=10 instance, BIN=10'd1000, START: DONE after 10 cycles; digits 0,1,0,0,0.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (double dabble, one bit per clock).
// It captures BIN on request, shifts it through a five-nibble scratch over WIDTH cycles,
// then holds the resulting digits and pulses DONE for one cycle.
module bin2bcd_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             CLOCK_50,
    input  logic             RESET,
    input  logic             START,
    input  logic             AUTO,
    input  logic [WIDTH-1:0] BIN,
    output logic             BUSY,
    output logic             DONE,
    output logic [3:0]       BCD0,
    output logic [3:0]       BCD1,
    output logic [3:0]       BCD2,
    output logic [3:0]       BCD3,
    output logic [3:0]       BCD4
);

    localparam int unsigned CNT_W  = 5;
    localparam int unsigned NDIG   = 5;
    localparam int unsigned SCR_W  = 4 * NDIG;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [WIDTH-1:0]   op_q,    op_d;
    logic [SCR_W-1:0]   scr_q,   scr_d;
    logic [SCR_W-1:0]   bcd_q,   bcd_d;
    logic               done_q,  done_d;

    logic               req_c;
    logic               last_c;
    logic [SCR_W-1:0]   corr_c;
    logic [SCR_W-1:0]   shifted_c;

    assign req_c  = START | AUTO;
    assign last_c = (cnt_q == CNT_W'(1));

    // Add 3 to every nibble that is 5 or more, then shift the operand MSB into bit 0
    always_comb begin
        corr_c = scr_q;
        for (int i = 0; i < int'(NDIG); i++) begin
            if (scr_q[4*i +: 4] >= 4'd5) begin
                corr_c[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
            end
        end
        shifted_c = {corr_c[SCR_W-2:0], op_q[WIDTH-1]};
    end

    // State register
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: leave IDLE on a request, return after the last shift
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_c)  state_d = S_SHIFT;
            S_SHIFT: if (last_c) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output next values; everything holds unless updated below
    always_comb begin
        cnt_d  = cnt_q;
        op_d   = op_q;
        scr_d  = scr_q;
        bcd_d  = bcd_q;
        done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_c) begin
                    op_d  = BIN;
                    scr_d = '0;
                    cnt_d = CNT_W'(WIDTH);
                end
            end
            S_SHIFT: begin
                scr_d = shifted_c;
                op_d  = op_q << 1;
                cnt_d = cnt_q - CNT_W'(1);
                if (last_c) begin
                    bcd_d  = shifted_c;
                    done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Working and output registers
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            cnt_q  <= '0;
            op_q   <= '0;
            scr_q  <= '0;
            bcd_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            op_q   <= op_d;
            scr_q  <= scr_d;
            bcd_q  <= bcd_d;
            done_q <= done_d;
        end
    end

    assign BUSY = (state_q == S_SHIFT);
    assign DONE = done_q;
    assign BCD0 = bcd_q[3:0];
    assign BCD1 = bcd_q[7:4];
    assign BCD2 = bcd_q[11:8];
    assign BCD3 = bcd_q[15:12];
    assign BCD4 = bcd_q[19:16];

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed bench for bin2bcd_seq at WIDTH=16 and WIDTH=10.
// Expected digits are written as hex nibbles, so 20'h12345 means digits 1,2,3,4,5.
module tb_bin2bcd_seq;

    logic        clk;
    logic        rst;
    logic        start16, auto16;
    logic [15:0] bin16;
    logic        busy16, done16;
    logic [3:0]  d16_0, d16_1, d16_2, d16_3, d16_4;
    logic        start10, auto10;
    logic [9:0]  bin10;
    logic        busy10, done10;
    logic [3:0]  d10_0, d10_1, d10_2, d10_3, d10_4;

    int total;
    int bad;

    bin2bcd_seq #(.WIDTH(16)) u_dut16 (
        .CLOCK_50(clk), .RESET(rst), .START(start16), .AUTO(auto16), .BIN(bin16),
        .BUSY(busy16), .DONE(done16),
        .BCD0(d16_0), .BCD1(d16_1), .BCD2(d16_2), .BCD3(d16_3), .BCD4(d16_4)
    );

    bin2bcd_seq #(.WIDTH(10)) u_dut10 (
        .CLOCK_50(clk), .RESET(rst), .START(start10), .AUTO(auto10), .BIN(bin10),
        .BUSY(busy10), .DONE(done10),
        .BCD0(d10_0), .BCD1(d10_1), .BCD2(d10_2), .BCD3(d10_3), .BCD4(d10_4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] digits16();
        return {d16_4, d16_3, d16_2, d16_1, d16_0};
    endfunction

    function automatic logic [19:0] digits10();
        return {d10_4, d10_3, d10_2, d10_1, d10_0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Tick until the selected instance raises DONE; lat counts edges, bounded
    task automatic wait_done(input int sel, input string tag, output int lat);
        logic ovl;
        logic dn;
        lat = 0;
        ovl = 1'b0;
        dn  = 1'b0;
        while (!dn && lat < 60) begin
            tick();
            lat++;
            dn = (sel == 0) ? done16 : done10;
            if ((sel == 0) ? (busy16 & done16) : (busy10 & done10)) ovl = 1'b1;
        end
        if (!dn) chk({tag, "_timeout"}, 32'(lat), 32'd0);
        chk({tag, "_busy_done_overlap"}, 32'(ovl), 32'd0);
    endtask

    // Count DONE pulses of the 16-bit instance over n cycles
    task automatic count_done(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (done16) cnt++;
        end
    endtask

    task automatic start_conv16(input logic [15:0] v);
        bin16   = v;
        start16 = 1'b1;
        tick();
        start16 = 1'b0;
    endtask

    logic [15:0] auto_vals [8];
    logic [19:0] auto_exp  [8];

    initial begin
        int lat;
        int lat2;
        int n;

        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        start16 = 1'b0; auto16 = 1'b0; bin16 = '0;
        start10 = 1'b0; auto10 = 1'b0; bin10 = '0;

        auto_vals[0] = 16'd0;     auto_exp[0] = 20'h00000;
        auto_vals[1] = 16'd9;     auto_exp[1] = 20'h00009;
        auto_vals[2] = 16'd10;    auto_exp[2] = 20'h00010;
        auto_vals[3] = 16'd99;    auto_exp[3] = 20'h00099;
        auto_vals[4] = 16'd100;   auto_exp[4] = 20'h00100;
        auto_vals[5] = 16'd9999;  auto_exp[5] = 20'h09999;
        auto_vals[6] = 16'd10000; auto_exp[6] = 20'h10000;
        auto_vals[7] = 16'd65534; auto_exp[7] = 20'h65534;

        // Reset state
        tick();
        tick();
        chk("rst_busy", 32'(busy16), 32'd0);
        chk("rst_done", 32'(done16), 32'd0);
        chk("rst_digits", 32'(digits16()), 32'd0);
        rst = 1'b0;
        tick();

        // Zero conversion: 16-cycle latency, one-cycle DONE
        start_conv16(16'd0);
        chk("zero_busy_after_accept", 32'(busy16), 32'd1);
        wait_done(0, "zero", lat);
        chk("zero_latency", 32'(lat), 32'd16);
        chk("zero_digits", 32'(digits16()), 32'h00000);
        chk("zero_busy_at_done", 32'(busy16), 32'd0);
        tick();
        chk("zero_done_one_cycle", 32'(done16), 32'd0);

        // Max value, then outputs held while BIN moves and START stays low
        start_conv16(16'hFFFF);
        wait_done(0, "max", lat);
        chk("max_latency", 32'(lat), 32'd16);
        chk("max_digits", 32'(digits16()), 32'h65535);
        bin16 = 16'd42;
        count_done(5, n);
        chk("max_no_extra_done", 32'(n), 32'd0);
        chk("max_digits_held", 32'(digits16()), 32'h65535);
        chk("max_idle_busy", 32'(busy16), 32'd0);

        // START and BIN changes mid-conversion are ignored
        start_conv16(16'd1023);
        for (int i = 0; i < 4; i++) tick();
        bin16   = 16'd7;
        start16 = 1'b1;
        tick();
        start16 = 1'b0;
        wait_done(0, "ignore", lat2);
        chk("ignore_latency", 32'(5 + lat2), 32'd16);
        chk("ignore_digits", 32'(digits16()), 32'h01023);
        count_done(20, n);
        chk("ignore_no_second_conv", 32'(n), 32'd0);
        chk("ignore_digits_held", 32'(digits16()), 32'h01023);

        // AUTO mode: new BIN each conversion, DONE period WIDTH+1
        bin16  = auto_vals[0];
        auto16 = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            wait_done(0, "auto", lat);
            chk($sformatf("auto_period_%0d", i), 32'(lat), (i == 0) ? 32'd16 : 32'd17);
            chk($sformatf("auto_digits_%0d", i), 32'(digits16()), 32'(auto_exp[i]));
            if (i < 7) bin16 = auto_vals[i+1];
            else       auto16 = 1'b0;
        end
        tick();
        chk("auto_off_idle", 32'(busy16), 32'd0);

        // Reset mid-conversion clears outputs immediately and yields no DONE
        start_conv16(16'd12345);
        wait_done(0, "pre_rst", lat);
        chk("pre_rst_digits", 32'(digits16()), 32'h12345);
        tick();
        start_conv16(16'd999);
        for (int i = 0; i < 7; i++) tick();
        chk("pre_rst_busy", 32'(busy16), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy16), 32'd0);
        chk("midrst_done", 32'(done16), 32'd0);
        chk("midrst_digits", 32'(digits16()), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        count_done(20, n);
        chk("midrst_no_done", 32'(n), 32'd0);
        chk("midrst_digits_stay_zero", 32'(digits16()), 32'd0);
        start_conv16(16'd4321);
        wait_done(0, "post_rst", lat);
        chk("post_rst_latency", 32'(lat), 32'd16);
        chk("post_rst_digits", 32'(digits16()), 32'h04321);

        // Narrow instance: 10-cycle latency
        bin10   = 10'd1000;
        start10 = 1'b1;
        tick();
        start10 = 1'b0;
        wait_done(1, "w10", lat);
        chk("w10_latency", 32'(lat), 32'd10);
        chk("w10_digits", 32'(digits10()), 32'h01000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
